mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
MEM pipeline stage between Execute and write-back. Takes the Execute result, rt value and memory control, and issues single-word requests to the data port of mainMem (initiator side, with busy handshake). Performs big-endian byte/half extraction with sign or zero extension, and read-modify-write for sb/sh. Emits the write-back packet to RegisterFile and stalls upstream while a memory transaction is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (memory word = one register)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
valid_in  in  1  instruction present from Execute
alu_result  in  [0:31]  effective address, or the result for non-memory ops
rt_data  in  [0:31]  store data
mem_read  in  1  load op
mem_write  in  1  store op
mem_size  in  [0:1]  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned  in  1  zero-extend loads (lbu/lhu)
rd_in  in  [0:4]  destination register
reg_write_in  in  1  write-back enable
stall_out  out  1  upstream must hold its inputs
mem_addr  out  [0:31]  word-aligned address (bits 30:31 = 0)
mem_data_out  out  [0:31]  write data to memory
mem_data_in  in  [0:31]  read data from memory
mem_enable  out  1  request valid
mem_wren  out  1  1 = write, 0 = read
mem_acc_size  out  [0:1]  always 00 (single word)
mem_busy  in  1  memory cannot accept the request this cycle
wb_valid  out  1  one-cycle write-back pulse
wb_data  out  [0:31]  write-back value
wb_rd  out  [0:4]  write-back register
wb_reg_write  out  1  RegisterFile write enable
misalign_err  out  1  one-cycle pulse with wb_valid on a misaligned access

Behaviour:
- Bit 0 = MSB. Byte offset = alu_result[30:31]. Offset 0 maps to bits [0:7] (big-endian).
- Reset: state IDLE. All outputs 0. Any partial RMW is abandoned and no write is issued.
- Inputs are latched when accepted: state IDLE and valid_in. valid_in in any other state is ignored.
- If mem_read and mem_write are both set, the op is treated as a load.
- stall_out is combinational. It is 1 when (IDLE and valid_in and (mem_read or mem_write) and aligned), or when the state is RD, RD_WAIT, RMW_RD, RMW_WAIT or WR.
- FSM states: IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, WR, DONE.
  - IDLE, on accept:
    - non-memory op -> DONE with wb_data = alu_result.
    - misaligned (half with bit31 = 1, or word with bits 30:31 != 00) -> DONE with misalign_err = 1 and wb_reg_write = 0.
    - load -> RD.
    - sw -> WR.
    - sb/sh -> RMW_RD.
  - RD / RMW_RD: mem_enable = 1, mem_wren = 0. If mem_busy, stay. Otherwise -> RD_WAIT / RMW_WAIT.
  - RD_WAIT: capture mem_data_in (valid one cycle after an accepted request), extract the lane, extend -> DONE.
  - RMW_WAIT: capture the word, merge rt_data's low byte/half into the addressed lane -> WR.
  - WR: mem_enable = 1, mem_wren = 1, mem_data_out = merged word (or rt_data for sw). If mem_busy, stay. Otherwise -> DONE.
  - DONE: wb_valid = 1 for one cycle. wb_reg_write = reg_write_in and not misaligned. -> IDLE.
- mem_addr and mem_data_out stay stable while mem_busy is high. mem_enable is 0 in IDLE and DONE.
- Latency from the accept cycle T, with no busy:
  - non-memory or misaligned: wb_valid at T+1.
  - sw: T+2.
  - load: T+3.
  - sb/sh: T+4.
  - Each busy cycle adds one.
- Stores drive wb_reg_write = 0 regardless of reg_write_in.

Decomposition:
- Add to control.vh: mem_size codes (SIZE_BYTE / HALF / WORD) and MEM stage state encodings.
- One combinational sub-module, byte_lane_unit: extract + sign/zero extend for loads, and lane merge for stores, keyed by offset and size.
- FSM and registers stay in mem_access_stage.

Test Plan:
1. Non-memory op, alu_result = 0x0000002A, rd_in = 5, reg_write_in = 1 -> at T+1: wb_valid = 1, wb_data = 0x0000002A, wb_rd = 5. mem_enable stays 0 and stall_out stays 0.
2. Memory word 0x12F45678 at 0x80020000:
   - lb @0x80020001 -> wb_data 0xFFFFFFF4 at T+3, mem_addr = 0x80020000.
   - lbu -> 0x000000F4.
   - lh @0x80020002 -> 0x00005678.
3. sh, rt_data = 0x0000BEEF, @0x80020002, memory word 0x11223344 -> one read, then a write of 0x1122BEEF. wb_valid at T+4 with wb_reg_write = 0.
4. sw 0xDEADBEEF @0x80020004 with mem_busy high for 3 cycles -> mem_wren = 1 with addr/data stable throughout. wb_valid at T+5 and stall_out high T..T+4.
5. lw @0x80020002 -> misalign_err = 1 and wb_valid = 1 at T+1, wb_reg_write = 0, mem_enable never asserted.
6. sb in progress, reset asserted in RMW_WAIT -> next cycle: state IDLE, all outputs 0, no write issued. A subsequent lw completes normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   SIZE_*       : mem_size encodings (11 behaves as a word access)
//   mem_state_t  : MEM stage FSM states
//   is_misaligned: alignment rule for a given size and byte offset
// Bit 0 is the MSB on every vector; offset 0 addresses bits [0:7].
package mem_access_stage_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [0:1] SIZE_BYTE = 2'b00;
  localparam logic [0:1] SIZE_HALF = 2'b01;
  localparam logic [0:1] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_RMW_RD,
    ST_RMW_WAIT,
    ST_WR,
    ST_DONE
  } mem_state_t;

  function automatic logic is_misaligned(input logic [0:1] size, input logic [0:1] off);
    if (size == SIZE_HALF)
      return off[1];
    else if (size inside {SIZE_WORD, 2'b11})
      return off != 2'b00;
    else
      return 1'b0;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Single-word data port between the MEM stage (master) and mainMem (slave).
//   mem_addr     : word-aligned request address
//   mem_data_out : write data
//   mem_data_in  : read data, valid the cycle after an accepted read
//   mem_enable   : request valid
//   mem_wren     : 1 = write, 0 = read
//   mem_acc_size : access size, always single word (00)
//   mem_busy     : memory cannot accept the request this cycle
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [0:ADDR_W-1] mem_addr;
  logic [0:DATA_W-1] mem_data_out;
  logic [0:DATA_W-1] mem_data_in;
  logic              mem_enable;
  logic              mem_wren;
  logic [0:1]        mem_acc_size;
  logic              mem_busy;

  modport master (
    output mem_addr, mem_data_out, mem_enable, mem_wren, mem_acc_size,
    input  mem_data_in, mem_busy
  );

  modport slave (
    input  mem_addr, mem_data_out, mem_enable, mem_wren, mem_acc_size,
    output mem_data_in, mem_busy
  );
endinterface

// File: rtl/mem_access_stage_byte_lane_unit.sv
// Combinational big-endian lane logic for the MEM stage.
//   i_word     : memory word just read
//   i_store    : store data; its low byte/half is the value written
//   i_off      : byte offset within the word (0 = bits [0:7])
//   i_size     : access size code
//   i_unsigned : zero-extend (1) or sign-extend (0) sub-word loads
//   o_load     : extracted and extended load value
//   o_merged   : i_word with the addressed lane replaced by store data
module mem_access_stage_byte_lane_unit
  import mem_access_stage_pkg::*;
(
  input  logic [0:WORD_W-1] i_word,
  input  logic [0:WORD_W-1] i_store,
  input  logic [0:1]        i_off,
  input  logic [0:1]        i_size,
  input  logic              i_unsigned,
  output logic [0:WORD_W-1] o_load,
  output logic [0:WORD_W-1] o_merged
);
  logic [0:7]  w_byte;
  logic [0:15] w_half;

  always_comb begin
    w_byte = '0;
    unique case (i_off)
      2'd0:    w_byte = i_word[0:7];
      2'd1:    w_byte = i_word[8:15];
      2'd2:    w_byte = i_word[16:23];
      default: w_byte = i_word[24:31];
    endcase
    // i_off[0] is address bit 30: selects the upper or lower half
    w_half = i_off[0] ? i_word[16:31] : i_word[0:15];

    o_load   = i_word;
    o_merged = i_word;
    if (i_size == SIZE_BYTE) begin
      o_load = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[0]}}, w_byte};
      unique case (i_off)
        2'd0:    o_merged[0:7]   = i_store[24:31];
        2'd1:    o_merged[8:15]  = i_store[24:31];
        2'd2:    o_merged[16:23] = i_store[24:31];
        default: o_merged[24:31] = i_store[24:31];
      endcase
    end else if (i_size == SIZE_HALF) begin
      o_load = i_unsigned ? {16'b0, w_half} : {{16{w_half[0]}}, w_half};
      if (i_off[0]) o_merged[16:31] = i_store[16:31];
      else          o_merged[0:15]  = i_store[16:31];
    end else begin
      o_merged = i_store;
    end
  end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues single-word loads/stores to mainMem, does
// big-endian sub-word extraction and read-modify-write for sb/sh, and emits
// a one-cycle write-back pulse to the RegisterFile.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   valid_in ... rd_in   : Execute result, store data and memory control
//   stall_out            : upstream must hold while a transaction is pending
//   mem_if (master)      : data port of mainMem with busy handshake
//   wb_*                 : write-back packet, valid for one cycle
//   misalign_err         : pulses with wb_valid on a misaligned access
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [0:ADDR_W-1] alu_result,
  input  logic [0:DATA_W-1] rt_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [0:1]        mem_size,
  input  logic              mem_unsigned,
  input  logic [0:4]        rd_in,
  input  logic              reg_write_in,
  output logic              stall_out,
  mem_access_stage_if.master mem_if,
  output logic              wb_valid,
  output logic [0:DATA_W-1] wb_data,
  output logic [0:4]        wb_rd,
  output logic              wb_reg_write,
  output logic              misalign_err
);
  mem_state_t        r_state, w_next;
  logic [0:ADDR_W-1] r_addr;
  logic [0:DATA_W-1] r_rt, r_word, r_wb;
  logic [0:1]        r_size;
  logic              r_uns, r_regw, r_mis, r_store;
  logic [0:4]        r_rd;
  logic              w_accept, w_is_mem, w_mis_in;
  logic [0:DATA_W-1] w_load, w_merged;

  assign w_accept = (r_state == ST_IDLE) && valid_in;
  assign w_is_mem = mem_read | mem_write;
  assign w_mis_in = w_is_mem && is_misaligned(mem_size, alu_result[ADDR_W-2:ADDR_W-1]);

  mem_access_stage_byte_lane_unit u_lane (
    .i_word     (mem_if.mem_data_in),
    .i_store    (r_rt),
    .i_off      (r_addr[ADDR_W-2:ADDR_W-1]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_next              = r_state;
    stall_out           = 1'b0;
    mem_if.mem_enable   = 1'b0;
    mem_if.mem_wren     = 1'b0;
    mem_if.mem_addr     = '0;
    mem_if.mem_data_out = '0;
    mem_if.mem_acc_size = '0;
    wb_valid            = 1'b0;
    wb_data             = '0;
    wb_rd               = '0;
    wb_reg_write        = 1'b0;
    misalign_err        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (valid_in) begin
          stall_out = w_is_mem && !w_mis_in;
          // a load wins when both mem_read and mem_write are set
          if (!w_is_mem || w_mis_in)                     w_next = ST_DONE;
          else if (mem_read)                             w_next = ST_RD;
          else if (mem_size inside {SIZE_WORD, 2'b11})   w_next = ST_WR;
          else                                           w_next = ST_RMW_RD;
        end
      end
      ST_RD, ST_RMW_RD: begin
        stall_out         = 1'b1;
        mem_if.mem_enable = 1'b1;
        mem_if.mem_addr   = {r_addr[0:ADDR_W-3], 2'b00};
        if (!mem_if.mem_busy)
          w_next = (r_state == ST_RD) ? ST_RD_WAIT : ST_RMW_WAIT;
      end
      ST_RD_WAIT: begin
        stall_out = 1'b1;
        w_next    = ST_DONE;
      end
      ST_RMW_WAIT: begin
        stall_out = 1'b1;
        w_next    = ST_WR;
      end
      ST_WR: begin
        stall_out           = 1'b1;
        mem_if.mem_enable   = 1'b1;
        mem_if.mem_wren     = 1'b1;
        mem_if.mem_addr     = {r_addr[0:ADDR_W-3], 2'b00};
        mem_if.mem_data_out = r_word;
        if (!mem_if.mem_busy) w_next = ST_DONE;
      end
      ST_DONE: begin
        wb_valid     = 1'b1;
        wb_data      = r_wb;
        wb_rd        = r_rd;
        wb_reg_write = r_regw && !r_mis && !r_store;
        misalign_err = r_mis;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rt    <= '0;
      r_word  <= '0;
      r_wb    <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
      r_rd    <= '0;
      r_regw  <= 1'b0;
      r_mis   <= 1'b0;
      r_store <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= alu_result;
        r_rt    <= rt_data;
        r_word  <= rt_data;     // sw writes rt_data unchanged
        r_wb    <= alu_result;  // non-memory result; loads overwrite it
        r_size  <= mem_size;
        r_uns   <= mem_unsigned;
        r_rd    <= rd_in;
        r_regw  <= reg_write_in;
        r_mis   <= w_mis_in;
        r_store <= mem_write & ~mem_read;
      end
      if (r_state == ST_RD_WAIT)  r_wb   <= w_load;
      if (r_state == ST_RMW_WAIT) r_word <= w_merged;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
module tb_mem_access_stage;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        regw;
    logic        mis;
    logic        chk_data;
    logic        memok;
    int unsigned lat;
    int unsigned nreq;
    int unsigned t0;
    int unsigned req0;
  } pkt_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] rt_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = '0;
  logic        mem_unsigned = 1'b0;
  logic [4:0]  rd_in = '0;
  logic        reg_write_in = 1'b0;
  logic        stall_out, wb_valid, wb_reg_write, misalign_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned req_cnt = 0;
  logic [31:0] cur_addr = '0;
  pkt_t        pq[$];
  logic [31:0] wq[$];
  int unsigned busy_q[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mem_access_stage_if #(.ADDR_W(32), .DATA_W(32)) mif();

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .alu_result(alu_result),
    .rt_data(rt_data), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .stall_out(stall_out), .mem_if(mif.master), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .misalign_err(misalign_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Memory responder: busy for a planned number of cycles per request,
  // read data one cycle after acceptance, writes checked against the model.
  initial begin : slave
    logic        in_req;
    logic [31:0] h_addr, h_data;
    logic        h_wren;
    int unsigned left;
    in_req = 1'b0; left = 0; h_addr = '0; h_data = '0; h_wren = 1'b0;
    mif.mem_busy = 1'b0;
    mif.mem_data_in = '0;
    forever begin
      @(posedge clock);
      if (!reset && mif.mem_enable && !mif.mem_busy) begin
        req_cnt++;
        chk("acc_size", 32'(mif.mem_acc_size), 32'd0);
        chk("req_addr", mif.mem_addr, cur_addr);
        if (mif.mem_wren) begin
          if (wq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got write %h to %h, required none", mif.mem_data_out, mif.mem_addr);
          end else begin
            chk("wr_data", mif.mem_data_out, wq.pop_front());
          end
          mem[mif.mem_addr] = mif.mem_data_out;
        end else begin
          mif.mem_data_in <= mem_get(mif.mem_addr);
        end
        in_req = 1'b0;
      end
      @(negedge clock);
      if (mif.mem_enable) begin
        if (!in_req) begin
          in_req = 1'b1;
          left   = (busy_q.size() != 0) ? busy_q.pop_front() : 0;
          h_addr = mif.mem_addr;
          h_data = mif.mem_data_out;
          h_wren = mif.mem_wren;
        end else begin
          chk("busy_addr_stable", mif.mem_addr, h_addr);
          chk("busy_data_stable", mif.mem_data_out, h_data);
          chk("busy_wren_stable", 32'(mif.mem_wren), 32'(h_wren));
        end
        mif.mem_busy = (left != 0);
        if (left != 0) left--;
      end else begin
        mif.mem_busy = 1'b0;
        in_req = 1'b0;
      end
    end
  end

  initial begin : monitor
    pkt_t p;
    forever begin
      @(negedge clock);
      #1;
      if (pq.size() != 0 && (cyc - pq[0].t0) < pq[0].lat)
        chk("stall_out", 32'(stall_out), 32'(pq[0].memok));
      if (wb_valid) begin
        if (pq.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_wb: got wb_valid=1 rd=%0d, required none", wb_rd);
        end else begin
          p = pq.pop_front();
          chk("latency", cyc - p.t0, p.lat);
          chk("wb_rd", 32'(wb_rd), 32'(p.rd));
          chk("wb_reg_write", 32'(wb_reg_write), 32'(p.regw));
          chk("misalign_err", 32'(misalign_err), 32'(p.mis));
          chk("mem_requests", req_cnt - p.req0, p.nreq);
          if (p.chk_data) chk("wb_data", wb_data, p.data);
        end
      end else if (misalign_err) begin
        chk("misalign_without_wb", 32'(misalign_err), 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_out), 0);
    chk({tag, "_enable"}, 32'(mif.mem_enable), 0);
    chk({tag, "_wren"}, 32'(mif.mem_wren), 0);
    chk({tag, "_addr"}, mif.mem_addr, 0);
    chk({tag, "_wdata"}, mif.mem_data_out, 0);
    chk({tag, "_accsize"}, 32'(mif.mem_acc_size), 0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 0);
    chk({tag, "_wb_regw"}, 32'(wb_reg_write), 0);
    chk({tag, "_misalign"}, 32'(misalign_err), 0);
  endtask

  // Reference model: computes the write-back value, the memory effect and
  // the cycle count of one instruction, then drives it and waits for it.
  task automatic issue(input logic rd_, input logic wr_, input logic [1:0] sz, input logic uns,
                       input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                       input logic rw, input int unsigned b0, input int unsigned b1);
    pkt_t        p;
    logic        is_mem, st, mis;
    logic [31:0] wa, word, nw, mask;
    int unsigned sh;
    logic [7:0]  bb;
    logic [15:0] hh;
    is_mem = rd_ | wr_;
    st     = wr_ & ~rd_;
    mis    = is_mem && ((sz == 2'd1 && alu[0]) || (sz >= 2'd2 && alu[1:0] != 2'd0));
    wa     = {alu[31:2], 2'b00};
    word   = ref_get(wa);
    nw     = rt;
    p.data = alu; p.rd = rd; p.mis = mis;
    p.chk_data = !st && !mis;
    p.regw  = rw && !mis && !st;
    p.memok = is_mem && !mis;
    p.lat = 1; p.nreq = 0;
    if (is_mem && !mis) begin
      if (!st) begin
        p.lat = 3 + b0; p.nreq = 1; busy_q.push_back(b0);
        if (sz == 2'd0) begin
          sh = 8 * (3 - int'(alu[1:0]));
          bb = 8'(word >> sh);
          p.data = uns ? {24'b0, bb} : {{24{bb[7]}}, bb};
        end else if (sz == 2'd1) begin
          hh = 16'(word >> (alu[1] ? 0 : 16));
          p.data = uns ? {16'b0, hh} : {{16{hh[15]}}, hh};
        end else begin
          p.data = word;
        end
      end else if (sz >= 2'd2) begin
        p.lat = 2 + b0; p.nreq = 1; busy_q.push_back(b0);
      end else begin
        p.lat = 4 + b0 + b1; p.nreq = 2; busy_q.push_back(b0); busy_q.push_back(b1);
        sh   = (sz == 2'd0) ? 8 * (3 - int'(alu[1:0])) : (alu[1] ? 0 : 16);
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        nw   = (word & ~mask) | ((rt << sh) & mask);
      end
      if (st) begin
        wq.push_back(nw);
        ref_mem[wa] = nw;
      end
    end
    cur_addr = wa;
    valid_in = 1'b1; mem_read = rd_; mem_write = wr_; mem_size = sz; mem_unsigned = uns;
    alu_result = alu; rt_data = rt; rd_in = rd; reg_write_in = rw;
    p.t0 = cyc; p.req0 = req_cnt;
    pq.push_back(p);
    @(negedge clock);
    valid_in = 1'b0;
    alu_result = $urandom(); rt_data = $urandom(); rd_in = 5'($urandom());
    mem_read = 1'($urandom()); mem_write = 1'($urandom()); mem_size = 2'($urandom());
    for (int i = 0; i < 60 && pq.size() != 0; i++) @(negedge clock);
    chk("drained", pq.size(), 0);
    if (pq.size() != 0) begin
      pq.delete(); wq.delete(); busy_q.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stim
    logic [1:0] k_sz;
    int unsigned kind;
    repeat (3) @(negedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // non-memory op
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000002A, 32'h0, 5'd5, 1'b1, 0, 0);
    // big-endian lane extraction
    poke(32'h80020000, 32'h12F45678);
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h80020001, 32'h0, 5'd3, 1'b1, 0, 0);
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h80020001, 32'h0, 5'd4, 1'b1, 0, 0);
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h80020002, 32'h0, 5'd6, 1'b1, 0, 0);
    // sh read-modify-write
    poke(32'h80020000, 32'h11223344);
    issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h80020002, 32'h0000BEEF, 5'd7, 1'b1, 0, 0);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h80020000, 32'h0, 5'd8, 1'b1, 0, 0);
    // sw with three busy cycles
    issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h80020004, 32'hDEADBEEF, 5'd9, 1'b1, 3, 0);
    // misaligned word load
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h80020002, 32'h0, 5'd10, 1'b1, 0, 0);

    // reset while an sb sits in RMW_WAIT
    poke(32'h80020010, 32'hA1B2C3D4);
    cur_addr = 32'h80020010;
    valid_in = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'd0; mem_unsigned = 1'b0;
    alu_result = 32'h80020011; rt_data = 32'h000000EE; rd_in = 5'd11; reg_write_in = 1'b1;
    @(negedge clock);
    valid_in = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check_all_zero("abort");
    reset = 1'b0;
    repeat (4) @(negedge clock);
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h80020010, 32'h0, 5'd12, 1'b1, 0, 0);

    // randomized mix
    for (int n = 0; n < 250; n++) begin
      kind = $urandom_range(0, 9);
      k_sz = 2'($urandom_range(0, 3));
      if (kind < 2)
        issue(1'b0, 1'b0, k_sz, 1'($urandom()), $urandom(), $urandom(), 5'($urandom()),
              1'($urandom()), 0, 0);
      else
        issue(kind < 6 || kind == 9, kind >= 6, k_sz, 1'($urandom()),
              32'h80020000 + $urandom_range(0, 31), $urandom(), 5'($urandom()),
              1'($urandom()), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
